// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, grant
// encoding and the byte-strobe width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_e;

    localparam int BYTE_BITS = 8;

    function automatic int strb_width(input int data_width);
        return data_width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side signals of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = strb_width(DATA_WIDTH)
) ();

    logic                  i_valid;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_err;

    logic                  d_valid;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [STRB_WIDTH-1:0] d_wstrb;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic                  mem_instr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_ready, i_rdata, i_err,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rdata, d_err,
        output mem_addr, mem_wdata, mem_wstrb, mem_instr,
        input  mem_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_ready, i_rdata, i_err,
        output d_valid, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rdata, d_err,
        input  mem_addr, mem_wdata, mem_wstrb, mem_instr,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a tie goes to the port opposite last_grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  logic   en,
    input  grant_e last_grant,
    output grant_e gnt,
    output logic   gnt_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt       = GNT_I;
        gnt_valid = en & (req_i | req_d);
        if (req_i && req_d) begin
            gnt = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (req_d) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one synchronous memory port
// (IDLE -> ACCESS -> RESP), blocking out-of-range addresses with an error.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int              ADDR_WIDTH = 32,
    parameter int              DATA_WIDTH = 32,
    parameter longint unsigned MEM_BYTES  = 64'd67108864
) (
    input logic               clk,
    input logic               resetn,
    mem_port_arbiter_if.slave bus
);

    localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = MEM_BYTES[ADDR_WIDTH:0];

    state_e                state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    grant_e                gnt_q, gnt_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;
    logic                  mem_instr_q, mem_instr_d;
    logic                  i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic                  i_err_q, i_err_d, d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    grant_e                arb_gnt;
    logic                  arb_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_oor;
    logic [DATA_WIDTH-1:0] resp_data;

    rr_arbiter2 u_rr_arbiter2 (
        .req_i      (bus.i_valid),
        .req_d      (bus.d_valid),
        .en         (state_q == IDLE),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_valid  (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_instr_d  = mem_instr_q;
        // Responses are single-cycle pulses, so they fall back to zero by default.
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_err_d      = 1'b0;
        d_err_d      = 1'b0;
        i_rdata_d    = '0;
        d_rdata_d    = '0;

        req_addr  = (arb_gnt == GNT_I) ? bus.i_addr : bus.d_addr;
        req_oor   = ({1'b0, req_addr} >= MEM_LIMIT);
        resp_data = err_q ? '0 : bus.mem_rdata;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d      = ACCESS;
                    gnt_d        = arb_gnt;
                    last_grant_d = arb_gnt;
                    err_d        = req_oor;
                    mem_addr_d   = req_addr;
                    mem_instr_d  = (arb_gnt == GNT_I);
                    mem_wstrb_d  = '0;
                    if (arb_gnt == GNT_D) begin
                        mem_wdata_d = bus.d_wdata;
                        mem_wstrb_d = req_oor ? '0 : bus.d_wstrb;
                    end
                end
            end
            ACCESS: begin
                // The memory samples the write at this closing edge; drop strobes right after.
                mem_wstrb_d = '0;
                state_d     = RESP;
            end
            RESP: begin
                if (gnt_q == GNT_I) begin
                    i_ready_d = 1'b1;
                    i_rdata_d = resp_data;
                    i_err_d   = err_q;
                end else begin
                    d_ready_d = 1'b1;
                    d_rdata_d = resp_data;
                    d_err_d   = err_q;
                end
                mem_instr_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_D;
            gnt_q        <= GNT_I;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            mem_instr_q  <= 1'b0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_instr_q  <= mem_instr_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.i_ready   = i_ready_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_instr = mem_instr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int              AW = 32;
    localparam int              DW = 32;
    localparam longint unsigned MB = 64'd67108864;
    localparam logic [31:0]     MB32 = 32'h0400_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Memory: registered read of the pre-write word, byte-enabled write.
    logic [31:0] mem [0:4095] = '{default: 32'h0};
    logic        pre_en  = 1'b0;
    logic [11:0] pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr[13:2]];
        if (pre_en) mem[pre_idx] <= pre_val;
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_wstrb[b]) mem[bus.mem_addr[13:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        pre;
        logic [31:0] pre_val;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic is_d, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic pre, input logic [31:0] pv,
                                input logic [31:0] er, input logic ee, input string name);
        vec_t v;
        v.is_d = is_d; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.pre = pre;
        v.pre_val = pv; v.exp_rdata = er; v.exp_err = ee; v.name = name;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.i_valid = 1'b0; bus.i_addr = '0;
        bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        logic [31:0] addr_seen, word_before;
        logic [3:0]  strb_seen, strb_exp;
        logic [1:0]  instr_seen;
        logic [67:0] resp, resp_exp;
        logic [11:0] idx;
        int          lat, strb_cycles;
        idx = v.addr[13:2];
        if (v.pre) preload(idx, v.pre_val);
        @(negedge clk);
        word_before = mem[idx];
        if (v.is_d) begin
            bus.d_valid = 1'b1; bus.d_addr = v.addr; bus.d_wdata = v.wdata; bus.d_wstrb = v.wstrb;
        end else begin
            bus.i_valid = 1'b1; bus.i_addr = v.addr;
        end
        lat = 0; strb_cycles = 0; resp = '0;
        addr_seen = '0; strb_seen = '0; instr_seen = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.mem_wstrb != 4'h0) strb_cycles++;
            if (c == 1) begin
                addr_seen = bus.mem_addr; strb_seen = bus.mem_wstrb; instr_seen[0] = bus.mem_instr;
            end
            if (c == 2) instr_seen[1] = bus.mem_instr;
            if (bus.i_ready || bus.d_ready) begin
                lat  = c;
                resp = {bus.i_ready, bus.i_rdata, bus.i_err, bus.d_ready, bus.d_rdata, bus.d_err};
            end
        end
        idle_inputs();
        strb_exp = (v.is_d && !v.exp_err) ? v.wstrb : 4'h0;
        resp_exp = v.is_d ? {1'b0, 32'h0, 1'b0, 1'b1, v.exp_rdata, v.exp_err}
                          : {1'b1, v.exp_rdata, v.exp_err, 1'b0, 32'h0, 1'b0};
        check({v.name, "_latency"}, 128'(lat), 128'(3));
        check({v.name, "_resp"}, 128'(resp), 128'(resp_exp));
        check({v.name, "_mem_addr"}, 128'(addr_seen), 128'(v.addr));
        check({v.name, "_wstrb"}, 128'({strb_seen, 4'(strb_cycles)}),
              128'({strb_exp, (strb_exp != 4'h0) ? 4'd1 : 4'd0}));
        check({v.name, "_instr"}, 128'(instr_seen), 128'(v.is_d ? 2'b00 : 2'b11));
        @(negedge clk);
        check({v.name, "_single_pulse"}, 128'({bus.i_ready, bus.d_ready}), 128'(0));
        if (v.exp_err) check({v.name, "_word_kept"}, 128'(mem[idx]), 128'(word_before));
    endtask

    // Randomized traffic model: one access at a time, fixed 3-cycle cadence,
    // round-robin on ties, word array for the 0x1000..0x10FC region.
    task automatic random_test(input int n_cycles);
        logic [31:0] mm [0:63];
        logic [31:0] addr, maddr, mdata;
        logic [3:0]  mstrb;
        logic        pend, merr, is_d;
        grant_e      mport, mlast, g;
        int          next_free, acc_cyc, rdy_cyc, k;
        logic [72:0] act, exp;
        for (int i = 0; i < 64; i++) mm[i] = 32'h0;
        pend = 1'b0; mlast = GNT_D; next_free = 0; acc_cyc = -10; rdy_cyc = -10; k = 0;
        mport = GNT_I; maddr = '0; mdata = '0; mstrb = '0; merr = 1'b0;
        repeat (n_cycles + 20) begin
            @(negedge clk);
            exp = {pend && rdy_cyc == k && mport == GNT_I,
                   (pend && rdy_cyc == k && mport == GNT_I) ? mdata : 32'h0,
                   pend && rdy_cyc == k && mport == GNT_I && merr,
                   pend && rdy_cyc == k && mport == GNT_D,
                   (pend && rdy_cyc == k && mport == GNT_D) ? mdata : 32'h0,
                   pend && rdy_cyc == k && mport == GNT_D && merr,
                   (pend && acc_cyc == k) ? mstrb : 4'h0,
                   pend && mport == GNT_I && (k == acc_cyc || k == acc_cyc + 1)};
            act = {bus.i_ready, bus.i_rdata, bus.i_err, bus.d_ready, bus.d_rdata, bus.d_err,
                   bus.mem_wstrb, bus.mem_instr};
            check("rand_cycle", 128'(act), 128'(exp));
            if (pend && acc_cyc == k) check("rand_mem_addr", 128'(bus.mem_addr), 128'(maddr));
            if (pend && rdy_cyc == k) begin
                pend = 1'b0;
                if (mport == GNT_I) bus.i_valid = 1'b0; else bus.d_valid = 1'b0;
            end
            if (k < n_cycles) begin
                if (!bus.i_valid && $urandom_range(0, 2) != 0) begin
                    bus.i_valid = 1'b1;
                    bus.i_addr  = ($urandom_range(0, 9) == 0) ? MB32 + 32'(4 * $urandom_range(0, 15))
                                                            : 32'h1000 + 32'(4 * $urandom_range(0, 63));
                end
                if (!bus.d_valid && $urandom_range(0, 2) != 0) begin
                    bus.d_valid = 1'b1;
                    bus.d_addr  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                                            : 32'h1000 + 32'(4 * $urandom_range(0, 63));
                    bus.d_wdata = $urandom;
                    bus.d_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                end
            end
            if (k + 1 >= next_free && (bus.i_valid || bus.d_valid)) begin
                if (bus.i_valid && bus.d_valid) g = (mlast == GNT_D) ? GNT_I : GNT_D;
                else g = bus.i_valid ? GNT_I : GNT_D;
                is_d  = (g == GNT_D);
                addr  = is_d ? bus.d_addr : bus.i_addr;
                merr  = (64'(addr) >= MB);
                mdata = merr ? 32'h0 : mm[(addr - 32'h1000) >> 2];
                mstrb = (is_d && !merr) ? bus.d_wstrb : 4'h0;
                for (int b = 0; b < 4; b++) begin
                    if (mstrb[b]) mm[(addr - 32'h1000) >> 2][8*b +: 8] = bus.d_wdata[8*b +: 8];
                end
                mport = g; mlast = g; maddr = addr; pend = 1'b1;
                acc_cyc = k + 1; rdy_cyc = k + 3; next_free = k + 4;
            end
            k++;
        end
        check("rand_drained", 128'({pend, bus.i_valid, bus.d_valid}), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [9];
        grant_e       order [$];
        int           when [$];
        int           nrdy;
        logic [127:0] exp_order, act_order;

        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              128'({bus.i_ready, bus.i_rdata, bus.i_err, bus.d_ready, bus.d_rdata, bus.d_err}), 128'(0));
        check("reset_mem_side",
              128'({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_instr}), 128'(0));
        resetn = 1'b1;

        // Tie from reset: both ports request continuously for four accesses.
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_addr = 32'h10;
        bus.d_valid = 1'b1; bus.d_addr = 32'h14; bus.d_wstrb = 4'h0;
        nrdy = 0;
        for (int c = 1; c <= 16 && nrdy < 4; c++) begin
            @(negedge clk);
            check("tie_no_overlap", 128'(bus.i_ready && bus.d_ready), 128'(0));
            if (bus.i_ready) begin order.push_back(GNT_I); when.push_back(c); nrdy++; end
            if (bus.d_ready) begin order.push_back(GNT_D); when.push_back(c); nrdy++; end
        end
        idle_inputs();
        check("tie_count", 128'(nrdy), 128'(4));
        exp_order = '0; act_order = '0;
        for (int j = 0; j < 4; j++) begin
            exp_order[j*8 +: 8] = 8'(3 + 3 * j);
            act_order[j*8 +: 8] = (j < when.size()) ? 8'(when[j]) : 8'hFF;
            exp_order[64 + j]   = (j % 2 == 1);
            act_order[64 + j]   = (j < order.size()) ? (order[j] == GNT_D) : 1'bx;
        end
        check("tie_order_and_spacing", act_order, exp_order);
        repeat (3) @(negedge clk);

        vecs[0] = mk(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h0000_0013, 32'h0000_0013, 1'b0, "fetch_read");
        vecs[1] = mk(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 1'b1, 32'h1122_3344, 32'h1122_3344, 1'b0, "partial_write");
        vecs[2] = mk(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h1122_BEEF, 1'b0, "read_after_write");
        vecs[3] = mk(1'b1, MB32, 32'h5A5A_5A5A, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1, "oor_write");
        vecs[4] = mk(1'b0, MB32 - 32'd4, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "last_word");
        vecs[5] = mk(1'b0, MB32, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, "oor_fetch");
        vecs[6] = mk(1'b1, 32'h102, 32'h0, 4'h0, 1'b0, 32'h0, 32'h1122_BEEF, 1'b0, "misaligned_read");
        vecs[7] = mk(1'b1, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, "top_addr_read");
        vecs[8] = mk(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h1122_BEEF, 1'b0, "fetch_sees_write");
        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // Reset during the ACCESS cycle of a write.
        preload(12'h080, 32'hAAAA_AAAA);
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'hF;
        @(negedge clk);
        check("midreset_strobe_live", 128'(bus.mem_wstrb), 128'(4'hF));
        #1 resetn = 1'b0;
        #1 check("midreset_strobe_async_clear", 128'(bus.mem_wstrb), 128'(0));
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.d_ready || bus.i_ready) nrdy++;
        end
        check("midreset_no_ready", 128'(nrdy), 128'(0));
        check("midreset_word_kept", 128'(mem[12'h080]), 128'(32'hAAAA_AAAA));
        do_txn(mk(1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0, 32'hAAAA_AAAA, 1'b0, "post_reset_idle"));

        // Idle bus.
        repeat (20) begin
            @(negedge clk);
            check("idle_bus",
                  128'({bus.i_ready, bus.d_ready, bus.i_err, bus.d_err, bus.mem_wstrb, bus.mem_instr}), 128'(0));
        end

        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        random_test(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
